// File: rtl/mul_mant_pipe_if.sv
// Handshake bundle for the pipelined mantissa multiplier.
// Operand side (in_*) and result side (out_*) plus occupancy.
interface mul_mant_pipe_if #(
    parameter int MANT_W  = 11,
    parameter int TAG_W   = 4,
    parameter int LATENCY = 2
);
    localparam int OCC_W = $clog2(LATENCY + 1);

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W-1:0] in_a;
    logic [MANT_W-1:0] in_b;
    logic [TAG_W-1:0]  in_tag;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W+1:0] out_result;
    logic              out_overflow;
    logic              out_round_loss;
    logic              out_zero;
    logic [TAG_W-1:0]  out_tag;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        output in_valid,
        output in_a,
        output in_b,
        output in_tag,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_overflow,
        input  out_round_loss,
        input  out_zero,
        input  out_tag,
        input  occupancy
    );

    modport slave (
        input  in_valid,
        input  in_a,
        input  in_b,
        input  in_tag,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_overflow,
        output out_round_loss,
        output out_zero,
        output out_tag,
        output occupancy
    );
endinterface

// File: rtl/mul_mant_pipe.sv
// Pipelined unsigned mantissa multiplier with elastic global stall.
// Produces rounding-ready mantissa (+R,S), overflow, sticky and zero.
module mul_mant_pipe #(
    parameter int MANT_W    = 11,
    parameter int LATENCY   = 2,
    parameter int NORMALIZE = 0,
    parameter int TAG_W     = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    mul_mant_pipe_if.slave bus
);
    localparam int W     = MANT_W;
    localparam int PW    = 2 * MANT_W;
    localparam int RW    = MANT_W + 2;
    localparam int BL    = MANT_W / 2;
    localparam int OCC_W = $clog2(LATENCY + 1);

    logic                 adv;
    logic                 acc;
    logic [LATENCY-1:0]   vld_q;
    logic [LATENCY-1:0]   vld_d;
    logic [OCC_W-1:0]     occ_q;
    logic [OCC_W-1:0]     occ_d;
    logic [TAG_W-1:0]     tag_q [LATENCY];
    logic [PW-1:0]        pre_p;
    logic [RW-1:0]        res_q;
    logic [RW-1:0]        res_d;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 rl_q;
    logic                 rl_d;
    logic                 zero_q;
    logic                 zero_d;

    // The whole pipe moves only when the last stage is empty or drained.
    assign adv          = !vld_q[LATENCY-1] || bus.out_ready;
    assign bus.in_ready = adv && !flush && !rst;
    assign acc          = bus.in_valid && bus.in_ready;

    // Next valid vector: shift toward the output when advancing.
    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = acc;
            for (int i = 1; i < LATENCY; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Occupancy tracks the valid vector one-for-one.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < LATENCY; i++) begin
            occ_d = occ_d + OCC_W'(vld_d[i]);
        end
    end

    // Valid bits and occupancy; flush and reset kill all in flight.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    // Tag sideband travels in lock-step with the payload.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else if (adv) begin
            tag_q[0] <= bus.in_tag;
            for (int i = 1; i < LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Product datapath: b split in halves, halves merged one stage later.
    generate
        if (LATENCY == 1) begin : g_l1
            assign pre_p = PW'(bus.in_a) * PW'(bus.in_b);
        end else begin : g_ln
            logic [PW-1:0] lo_q;
            logic [PW-1:0] hi_q;
            logic [PW-1:0] pp_sum;

            // Two half-width partial products captured at accept.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lo_q <= '0;
                    hi_q <= '0;
                end else if (adv) begin
                    lo_q <= PW'(bus.in_a) * PW'(bus.in_b[BL-1:0]);
                    hi_q <= PW'(bus.in_a) * PW'(bus.in_b[W-1:BL]);
                end
            end

            assign pp_sum = lo_q + (hi_q << BL);

            if (LATENCY == 2) begin : g_l2
                assign pre_p = pp_sum;
            end else begin : g_lm
                logic [PW-1:0] mid_q [LATENCY-2];

                // Full product delayed through the middle stages.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int i = 0; i < LATENCY - 2; i++) begin
                            mid_q[i] <= '0;
                        end
                    end else if (adv) begin
                        mid_q[0] <= pp_sum;
                        for (int i = 1; i < LATENCY - 2; i++) begin
                            mid_q[i] <= mid_q[i-1];
                        end
                    end
                end

                assign pre_p = mid_q[LATENCY-3];
            end
        end
    endgenerate

    // Slice the full product into mantissa, R, S and flags.
    always_comb begin
        ovf_d  = pre_p[PW-1];
        zero_d = ~|pre_p;
        if (NORMALIZE != 0 && ovf_d) begin
            res_d = pre_p[PW-1 -: RW];
            rl_d  = |pre_p[W-3:0];
        end else begin
            res_d = pre_p[PW-2 -: RW];
            rl_d  = |pre_p[W-4:0];
        end
    end

    // Last stage: sliced result registered straight onto the ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q  <= '0;
            ovf_q  <= 1'b0;
            rl_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            rl_q   <= rl_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid      = vld_q[LATENCY-1];
    assign bus.out_result     = res_q;
    assign bus.out_overflow   = ovf_q;
    assign bus.out_round_loss = rl_q;
    assign bus.out_zero       = zero_q;
    assign bus.out_tag        = tag_q[LATENCY-1];
    assign bus.occupancy      = occ_q;
endmodule
